// File: rtl/fixed_lut_activation_stream.sv
`default_nettype none
// ============================================================================
//  Module   : fixed_lut_activation_stream
//  Summary  : Streaming, runtime-writable activation lookup applied to
//             PARALLELISM channels per beat through a 2-stage stall pipeline.
//  Revision : 1.0 - initial release
// ============================================================================

module fixed_lut_activation_stream #(
    parameter int DATA_IN_WIDTH  = 4,
    parameter int DATA_OUT_WIDTH = 4,
    parameter int PARALLELISM    = 2,
    parameter logic [(1 << DATA_IN_WIDTH)*DATA_OUT_WIDTH-1:0] LUT_INIT =
        64'h0FFF_FFFF_6543_2110
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [PARALLELISM*DATA_IN_WIDTH-1:0] data_in_0,
    input  logic                                 data_in_0_valid,
    output logic                                 data_in_0_ready,
    output logic [PARALLELISM*DATA_OUT_WIDTH-1:0] data_out_0,
    output logic                                 data_out_0_valid,
    input  logic                                 data_out_0_ready,
    input  logic                                 lut_wr_en,
    input  logic [DATA_IN_WIDTH-1:0]             lut_wr_addr,
    input  logic [DATA_OUT_WIDTH-1:0]            lut_wr_data
);

    localparam int c_lut_depth = 1 << DATA_IN_WIDTH;

    logic [DATA_OUT_WIDTH-1:0]              r_lut [c_lut_depth];
    logic                                   r_a_valid;
    logic [PARALLELISM*DATA_IN_WIDTH-1:0]   r_a_data;
    logic                                   r_b_valid;
    logic [PARALLELISM*DATA_OUT_WIDTH-1:0]  r_b_data;
    logic [PARALLELISM*DATA_OUT_WIDTH-1:0]  w_lookup;
    logic                                   w_adv_a;
    logic                                   w_adv_b;

    assign w_adv_b = !r_b_valid || data_out_0_ready;
    assign w_adv_a = !r_a_valid || w_adv_b;

    // Table reads sample the pre-edge contents, so a same-edge write is never forwarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_lut_depth; i++) begin
                r_lut[i] <= LUT_INIT[i*DATA_OUT_WIDTH +: DATA_OUT_WIDTH];
            end
        end else if (lut_wr_en) begin
            r_lut[lut_wr_addr] <= lut_wr_data;
        end
    end

    generate
        for (genvar k = 0; k < PARALLELISM; k++) begin : g_lane
            assign w_lookup[k*DATA_OUT_WIDTH +: DATA_OUT_WIDTH] =
                r_lut[r_a_data[k*DATA_IN_WIDTH +: DATA_IN_WIDTH]];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_valid <= 1'b0;
            r_a_data  <= '0;
        end else if (w_adv_a) begin
            r_a_valid <= data_in_0_valid;
            r_a_data  <= data_in_0;
        end
    end

    // Stage B data only moves when a real beat arrives; bubbles keep the last value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_b_valid <= 1'b0;
            r_b_data  <= '0;
        end else if (w_adv_b) begin
            r_b_valid <= r_a_valid;
            if (r_a_valid) begin
                r_b_data <= w_lookup;
            end
        end
    end

    assign data_in_0_ready  = w_adv_a;
    assign data_out_0       = r_b_data;
    assign data_out_0_valid = r_b_valid;

endmodule

`default_nettype wire

// File: doc/fixed_lut_activation_stream.md
Name: fixed_lut_activation_stream

Overview:
- Streaming, parametrised successor to the fixed 4-in/4-out SiLU lookup.
- Applies one shared 2^DATA_IN_WIDTH-entry activation table to PARALLELISM channels per beat.
- Adds valid/ready handshaking, a 2-stage stall-capable pipeline, and a runtime table write port so the same block can serve SiLU, GELU, sigmoid and other fixed-point maps.
- Sits between a quantised linear/conv output stream and the next layer's input stream.

Parameters:
- DATA_IN_WIDTH, 4: input code width in bits. Table depth is 2^DATA_IN_WIDTH.
- DATA_OUT_WIDTH, 4: output code width in bits.
- PARALLELISM, 2: channels per beat. Must be 1 or more.
- LUT_INIT, 64'h0FFF_FFFF_6543_2110: reset contents of the table, packed with entry i at bits [i*DATA_OUT_WIDTH +: DATA_OUT_WIDTH]. Width is (2^DATA_IN_WIDTH)*DATA_OUT_WIDTH. The default is the 4/4 SiLU map.

Ports:
- clk  in  1  clock; all state on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in_0  in  PARALLELISM*DATA_IN_WIDTH  input codes; channel k at [k*DATA_IN_WIDTH +: DATA_IN_WIDTH].
- data_in_0_valid  in  1  input beat valid.
- data_in_0_ready  out  1  block can accept an input beat.
- data_out_0  out  PARALLELISM*DATA_OUT_WIDTH  mapped codes, same channel packing as the input.
- data_out_0_valid  out  1  output beat valid.
- data_out_0_ready  in  1  downstream accepts the output beat.
- lut_wr_en  in  1  table write strobe.
- lut_wr_addr  in  DATA_IN_WIDTH  table entry to write.
- lut_wr_data  in  DATA_OUT_WIDTH  new entry value.

Behaviour:
- Reset (rst=0, asynchronous):
  - table loads LUT_INIT;
  - stage A and stage B valid flags clear;
  - data_out_0 = 0, data_out_0_valid = 0;
  - data_in_0_ready = 1 combinationally from the cleared state.
  - Beats in flight when reset asserts are discarded, not emitted.
- Stage A register: captures data_in_0 when an input handshake occurs (data_in_0_valid & data_in_0_ready).
- Stage B register: holds the looked-up outputs, which drive data_out_0 directly.
- Advance rules:
  - advB = !B_valid | data_out_0_ready
  - advA = !A_valid | advB
  - data_in_0_ready = advA. This is combinational from state and data_out_0_ready only; it never depends on data_in_0_valid.
- Cycle behaviour:
  - On advB: B_valid <= A_valid, and if A_valid, B data <= table[A index] for each channel independently.
  - On advA: A_valid <= data_in_0_valid, and A data <= data_in_0.
- Latency: 2 cycles from the input handshake to data_out_0_valid when unstalled. Throughput is 1 beat per cycle.
- Capacity: 2 beats. With the output stalled, exactly 2 beats are accepted, then data_in_0_ready drops.
- Stall stability: while data_out_0_valid=1 and data_out_0_ready=0, data_out_0 and data_out_0_valid hold stable. Stage A holds if occupied.
- Lookup is a pure index into the table. No sign handling in this block; signedness is encoded in the table contents.
- Table write: when lut_wr_en=1, table[lut_wr_addr] <= lut_wr_data at the clock edge. Writes are accepted regardless of stream activity.
- Read/write collision: a lookup performed on the same edge as a write to the same address uses the OLD value. Lookups on later edges use the new value. Write data is never forwarded.
- Two channels with the same index in one beat both receive the same value.
- No wrap-around, counters or overflow exist. An invalid input beat (data_in_0_valid=0) occupies no slot.

Test Plan:
- Reset with PARALLELISM=2 and default LUT_INIT -> data_out_0_valid=0, data_out_0=0, data_in_0_ready=1.
- Send beats {ch1=0x3, ch0=0x8}, then {0xF, 0x1}, with data_out_0_ready=1 -> two cycles after each handshake, outputs {0x2, 0xF} then {0x0, 0x1}.
- Hold data_out_0_ready=0 and offer 3 beats -> first two accepted, data_in_0_ready=0 on the third, data_out_0 held stable. Release ready -> beats emerge in order with none lost or duplicated.
- Write addr 0x3 = 0x7 in an idle cycle, then send {0x3, 0x3} -> output {0x7, 0x7}.
- Write addr 0x5 = 0xA on the same edge that stage A (holding 0x5) advances -> output 0x4. The next 0x5 lookup returns 0xA.
- Assert rst mid-stream with 2 beats in flight -> data_out_0_valid drops immediately, no stale beat after release, and table returns to LUT_INIT (0x3 maps to 0x2 again).
